// File: rtl/wisc_decode_issue_if.sv
// Handshake and decoded-instruction bus between fetch, the decode/issue stage
// and the execute stage.
interface wisc_decode_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  op;
   logic [1:0]  sub_op;
   logic        inv_a;
   logic        inv_b;
   logic        cin;
   logic [15:0] imm;
   logic        b_sel_imm;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  rd;
   logic        reg_wr;

   // Fetch/execute side: drives instructions in and consumes decoded entries.
   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, op, sub_op, inv_a, inv_b, cin, imm,
             b_sel_imm, rs, rt, rd, reg_wr
   );

   // Decode/issue stage side.
   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, op, sub_op, inv_a, inv_b, cin, imm,
             b_sel_imm, rs, rt, rd, reg_wr
   );
endinterface

// File: rtl/wisc_decode_issue.sv
// WISC-SP13 decode/issue stage: decodes each accepted instruction into ALU and
// register-file controls, buffers up to two decoded entries in FIFO order and
// issues them to execute. Accepting HALT stops intake until reset.
module wisc_decode_issue #(
   parameter int       DEPTH   = 2,    // fixed at 2
   parameter bit [2:0] R7_LINK = 3'd7
) (
   input  logic                clk,
   input  logic                rst_n,
   wisc_decode_issue_if.slave  bus,
   output logic                halted
);

   typedef struct packed {
      logic [4:0]  op;
      logic [1:0]  sub_op;
      logic        inv_a;
      logic        inv_b;
      logic        cin;
      logic [15:0] imm;
      logic        b_sel_imm;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic        reg_wr;
   } dec_t;

   localparam logic [4:0] OP_HALT = 5'b00000;

   dec_t        dec;
   dec_t        mem [2];
   dec_t        head;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        halt_seen;
   logic        push;
   logic        pop;
   logic [4:0]  opc;
   logic [15:0] sext5;
   logic [15:0] zext5;
   logic [15:0] sext8;
   logic [15:0] zext8;
   logic [15:0] sext11;

   assign opc    = bus.instr[15:11];
   assign sext5  = {{11{bus.instr[4]}}, bus.instr[4:0]};
   assign zext5  = {11'd0, bus.instr[4:0]};
   assign sext8  = {{8{bus.instr[7]}}, bus.instr[7:0]};
   assign zext8  = {8'd0, bus.instr[7:0]};
   assign sext11 = {{5{bus.instr[10]}}, bus.instr[10:0]};

   // Combinational decode of the incoming instruction word.
   always_comb begin
      // NOTE: every field gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      dec        = '0;
      dec.op     = opc;
      dec.rs     = bus.instr[10:8];
      dec.rt     = bus.instr[7:5];
      casez (opc)
         5'b11011: begin   // ADD/SUB/XOR/ANDN
            dec.sub_op = bus.instr[1:0];
            dec.rd     = bus.instr[4:2];
            dec.reg_wr = 1'b1;
            case (bus.instr[1:0])
               2'b01:   begin dec.inv_a = 1'b1; dec.cin = 1'b1; end
               2'b11:   dec.inv_b = 1'b1;
               default: ;
            endcase
         end
         5'b11010: begin   // ROL/SLL/ROR/SRL
            dec.sub_op = bus.instr[1:0];
            dec.rd     = bus.instr[4:2];
            dec.reg_wr = 1'b1;
         end
         5'b111??: begin   // SEQ/SLT/SLE compare via A-B; SCO is a plain add
            dec.sub_op = bus.instr[1:0];
            dec.rd     = bus.instr[4:2];
            dec.reg_wr = 1'b1;
            if (opc[1:0] != 2'b11) begin
               dec.inv_b = 1'b1;
               dec.cin   = 1'b1;
            end
         end
         5'b11001: begin   // BTR
            dec.rd     = bus.instr[4:2];
            dec.reg_wr = 1'b1;
         end
         5'b010??: begin   // ADDI/SUBI sign-extend, XORI/ANDNI zero-extend
            dec.imm       = opc[1] ? zext5 : sext5;
            dec.b_sel_imm = 1'b1;
            dec.rd        = bus.instr[7:5];
            dec.reg_wr    = 1'b1;
            dec.inv_a     = (opc[1:0] == 2'b01);
            dec.cin       = (opc[1:0] == 2'b01);
            dec.inv_b     = (opc[1:0] == 2'b11);
         end
         5'b101??: begin   // shift-immediates
            dec.imm       = zext5;
            dec.b_sel_imm = 1'b1;
            dec.rd        = bus.instr[7:5];
            dec.reg_wr    = 1'b1;
         end
         5'b1000?, 5'b10011: begin   // ST, LD, STU
            dec.imm       = sext5;
            dec.b_sel_imm = 1'b1;
            dec.rd        = bus.instr[7:5];
            dec.reg_wr    = (opc != 5'b10000);
         end
         5'b10010: begin   // SLBI
            dec.imm       = zext8;
            dec.b_sel_imm = 1'b1;
            dec.rd        = bus.instr[10:8];
            dec.reg_wr    = 1'b1;
         end
         5'b11000: begin   // LBI
            dec.imm       = sext8;
            dec.b_sel_imm = 1'b1;
            dec.rd        = bus.instr[10:8];
            dec.reg_wr    = 1'b1;
         end
         5'b011??: dec.imm = sext8;   // branches: imm goes to the PC adder
         5'b00100: dec.imm = sext11;  // J
         5'b00110: begin              // JAL
            dec.imm    = sext11;
            dec.rd     = R7_LINK;
            dec.reg_wr = 1'b1;
         end
         5'b00101: begin              // JR
            dec.imm       = sext8;
            dec.b_sel_imm = 1'b1;
         end
         5'b00111: begin              // JALR
            dec.imm       = sext8;
            dec.b_sel_imm = 1'b1;
            dec.rd        = R7_LINK;
            dec.reg_wr    = 1'b1;
         end
         default: ;                   // HALT, NOP, siic, RTI
      endcase
   end

   assign bus.in_ready  = (count < 2'(DEPTH)) & ~halt_seen;
   assign bus.out_valid = (count != 2'd0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   // Decoded-entry storage, written at the tail on accept.
   always_ff @(posedge clk) begin
      // NOTE: the entry array has no reset; count gates every read, so stale
      // contents are never observed.
      if (push) mem[wr_ptr] <= dec;
   end

   // FIFO pointers, occupancy and HALT tracking.
   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         halt_seen <= 1'b0;
         halted    <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
         if (push && dec.op == OP_HALT)  halt_seen <= 1'b1;
         if (pop && mem[rd_ptr].op == OP_HALT) halted <= 1'b1;
      end
   end

   // Head entry drives the outputs; everything reads zero while empty.
   always_comb begin
      head = bus.out_valid ? mem[rd_ptr] : '0;
   end

   assign bus.op        = head.op;
   assign bus.sub_op    = head.sub_op;
   assign bus.inv_a     = head.inv_a;
   assign bus.inv_b     = head.inv_b;
   assign bus.cin       = head.cin;
   assign bus.imm       = head.imm;
   assign bus.b_sel_imm = head.b_sel_imm;
   assign bus.rs        = head.rs;
   assign bus.rt        = head.rt;
   assign bus.rd        = head.rd;
   assign bus.reg_wr    = head.reg_wr;

endmodule

// File: tb/tb_wisc_decode_issue.sv
// Directed bench for wisc_decode_issue: a table of single instructions with
// hand-decoded fields, then sequences for back-to-back issue, output hold,
// reset flush and HALT.
module tb_wisc_decode_issue;

   typedef struct packed {
      logic [4:0]  op;
      logic [1:0]  sub_op;
      logic        inv_a;
      logic        inv_b;
      logic        cin;
      logic [15:0] imm;
      logic        b_sel_imm;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic        reg_wr;
   } dec_t;

   typedef struct {
      logic [15:0] instr;
      dec_t        exp;
      logic        chk_rd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic halted;
   int   n_checks = 0;
   int   n_fail   = 0;

   wisc_decode_issue_if bus ();

   wisc_decode_issue dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .halted (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic dec_t sample();
      dec_t d;
      d = {bus.op, bus.sub_op, bus.inv_a, bus.inv_b, bus.cin, bus.imm,
           bus.b_sel_imm, bus.rs, bus.rt, bus.rd, bus.reg_wr};
      return d;
   endfunction

   function automatic vec_t v(logic [15:0] ins, logic [4:0] op, logic [1:0] so,
                              logic ia, logic ib, logic ci, logic [15:0] imm,
                              logic bs, logic [2:0] rs, logic [2:0] rt,
                              logic [2:0] rd, logic rw, logic crd);
      vec_t r;
      r.instr  = ins;
      r.exp    = '{op, so, ia, ib, ci, imm, bs, rs, rt, rd, rw};
      r.chk_rd = crd;
      return r;
   endfunction

   vec_t vecs [19];

   initial begin
      dec_t d;

      //            instr     op        sub ia ib ci imm       bs rs rt rd rw chk_rd
      vecs[0]  = v(16'hDA65, 5'b11011, 2'd1, 1, 0, 1, 16'h0000, 0, 2, 3, 1, 1, 1); // SUB
      vecs[1]  = v(16'h417F, 5'b01000, 2'd0, 0, 0, 0, 16'hFFFF, 1, 1, 3, 3, 1, 1); // ADDI -1
      vecs[2]  = v(16'h5170, 5'b01010, 2'd0, 0, 0, 0, 16'h0010, 1, 1, 3, 3, 1, 1); // XORI 16
      vecs[3]  = v(16'h4822, 5'b01001, 2'd0, 1, 0, 1, 16'h0002, 1, 0, 1, 1, 1, 1); // SUBI
      vecs[4]  = v(16'hDB97, 5'b11011, 2'd3, 0, 1, 0, 16'h0000, 0, 3, 4, 5, 1, 1); // ANDN
      vecs[5]  = v(16'hF14C, 5'b11110, 2'd0, 0, 1, 1, 16'h0000, 0, 1, 2, 3, 1, 1); // SLE
      vecs[6]  = v(16'hF94C, 5'b11111, 2'd0, 0, 0, 0, 16'h0000, 0, 1, 2, 3, 1, 1); // SCO
      vecs[7]  = v(16'hD14E, 5'b11010, 2'd2, 0, 0, 0, 16'h0000, 0, 1, 2, 3, 1, 1); // ROR
      vecs[8]  = v(16'h5951, 5'b01011, 2'd0, 0, 1, 0, 16'h0011, 1, 1, 2, 2, 1, 1); // ANDNI
      vecs[9]  = v(16'hA95F, 5'b10101, 2'd0, 0, 0, 0, 16'h001F, 1, 1, 2, 2, 1, 1); // SLLI
      vecs[10] = v(16'h8A75, 5'b10001, 2'd0, 0, 0, 0, 16'hFFF5, 1, 2, 3, 3, 1, 1); // LD
      vecs[11] = v(16'h8264, 5'b10000, 2'd0, 0, 0, 0, 16'h0004, 1, 2, 3, 3, 0, 1); // ST
      vecs[12] = v(16'hC485, 5'b11000, 2'd0, 0, 0, 0, 16'hFF85, 1, 4, 4, 4, 1, 1); // LBI
      vecs[13] = v(16'h6580, 5'b01100, 2'd0, 0, 0, 0, 16'hFF80, 0, 5, 4, 0, 0, 0); // BEQZ
      vecs[14] = v(16'h2400, 5'b00100, 2'd0, 0, 0, 0, 16'hFC00, 0, 4, 0, 0, 0, 0); // J
      vecs[15] = v(16'h2B7F, 5'b00101, 2'd0, 0, 0, 0, 16'h007F, 1, 3, 3, 0, 0, 0); // JR
      vecs[16] = v(16'h39FE, 5'b00111, 2'd0, 0, 0, 0, 16'hFFFE, 1, 1, 7, 7, 1, 1); // JALR
      vecs[17] = v(16'h37FF, 5'b00110, 2'd0, 0, 0, 0, 16'hFFFF, 0, 7, 7, 7, 1, 1); // JAL
      vecs[18] = v(16'h0800, 5'b00001, 2'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0); // NOP

      // Reset state
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.instr     = 16'hDA65;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_in_ready",  64'(bus.in_ready),  64'd1);
      check("reset_halted",    64'(halted),        64'd0);
      check("reset_fields",    64'(sample()),      64'd0);
      rst_n = 1'b1;
      tick();

      // Table: each instruction alone through an empty buffer, 1-cycle latency
      bus.out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         bus.in_valid = 1'b1;
         bus.instr    = vecs[i].instr;
         tick();
         bus.in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
         d = sample();
         if (!vecs[i].chk_rd) d.rd = 3'd0;
         check($sformatf("vec%0d_%h", i, vecs[i].instr), 64'(d), 64'(vecs[i].exp));
         tick();
      end
      check("table_drained", 64'(bus.out_valid), 64'd0);

      // Back-to-back ADDI then XORI with simultaneous push/pop at count 1
      bus.in_valid = 1'b1;
      bus.instr    = 16'h417F;
      tick();
      bus.instr = 16'h5170;
      check("b2b_first_op",  64'(bus.op),  64'(5'b01000));
      check("b2b_first_imm", 64'(bus.imm), 64'h0000_FFFF);
      check("b2b_first_rd",  64'(bus.rd),  64'd3);
      check("b2b_first_bsel", 64'(bus.b_sel_imm), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      check("b2b_second_valid", 64'(bus.out_valid), 64'd1);
      check("b2b_second_op",    64'(bus.op),  64'(5'b01010));
      check("b2b_second_imm",   64'(bus.imm), 64'h0000_0010);
      tick();
      check("b2b_drained", 64'(bus.out_valid), 64'd0);

      // Fill both entries with out_ready low, hold, then drain
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.instr     = 16'h92FF;
      tick();
      check("fill_ready_after_one", 64'(bus.in_ready), 64'd1);
      bus.instr = 16'h37FF;
      tick();
      bus.in_valid = 1'b0;
      check("fill_ready_full", 64'(bus.in_ready), 64'd0);
      check("fill_head_op",    64'(bus.op),  64'(5'b10010));
      check("fill_head_imm",   64'(bus.imm), 64'h0000_00FF);
      check("fill_head_rd",    64'(bus.rd),  64'd2);
      tick();
      tick();
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_imm",   64'(bus.imm), 64'h0000_00FF);
      check("hold_rd",    64'(bus.rd),  64'd2);
      bus.out_ready = 1'b1;
      tick();
      check("drain_ready_freed", 64'(bus.in_ready), 64'd1);
      check("drain_jal", 64'(sample()), 64'(vecs[17].exp));
      tick();
      check("drain_empty", 64'(bus.out_valid), 64'd0);

      // Reset with two entries buffered discards them
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.instr     = 16'hDA65;
      tick();
      bus.instr = 16'h417F;
      tick();
      bus.in_valid = 1'b0;
      check("pre_reset_full", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready",  64'(bus.in_ready),  64'd1);
      check("flush_halted",    64'(halted),        64'd0);
      check("flush_fields",    64'(sample()),      64'd0);
      bus.out_ready = 1'b1;
      tick();
      tick();
      tick();
      check("flush_no_issue", 64'(bus.out_valid), 64'd0);

      // HALT behind an ADDI; following SUB is held off
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.instr     = 16'h417F;
      tick();
      bus.instr = 16'h0000;
      tick();
      bus.instr = 16'hDA65;
      check("halt_in_ready", 64'(bus.in_ready), 64'd0);
      check("halt_head_addi", 64'(bus.op), 64'(5'b01000));
      bus.out_ready = 1'b1;
      tick();
      check("halt_still_blocked", 64'(bus.in_ready), 64'd0);
      check("halt_head_valid", 64'(bus.out_valid), 64'd1);
      check("halt_head_op",    64'(bus.op), 64'd0);
      check("halt_not_yet",    64'(halted), 64'd0);
      tick();
      check("halted_set",      64'(halted), 64'd1);
      check("halt_popped",     64'(bus.out_valid), 64'd0);
      tick();
      tick();
      tick();
      check("halt_sub_rejected", 64'(bus.out_valid), 64'd0);
      check("halt_ready_low",    64'(bus.in_ready), 64'd0);
      check("halted_sticky",     64'(halted), 64'd1);
      bus.in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wisc_decode_issue.md
Name: wisc_decode_issue

Overview:
- Registered instruction decode/issue stage for the WISC-SP13 datapath. It produces every ALU control input: op, sub_op, inv_a, inv_b, cin, immediate and B-select.
- It also produces register-file addresses and the write enable.
- Accepts 16-bit instruction words over a valid/ready handshake and holds them in a 2-entry decoded-instruction buffer.
- Issues to the execute stage over a second valid/ready handshake, and latches HALT.

Parameters:
- DEPTH, 2, number of decoded entries buffered; fixed at 2; other values are unsupported.
- R7_LINK, 3'd7, link register written by JAL/JALR.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  instr is valid
- in_ready  out  1  block can accept instr this cycle
- instr  in  16  WISC-SP13 instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage consumes head entry
- op  out  5  ALU Op (= instr[15:11])
- sub_op  out  2  ALU sub_op (= instr[1:0] for R-format, else 2'b00)
- inv_a, inv_b, cin  out  1 each  ALU operand-invert and carry-in controls
- imm  out  16  extended immediate
- b_sel_imm  out  1  ALU B operand = imm (1) or Rt (0)
- rs, rt, rd  out  3 each  register addresses
- reg_wr  out  1  instruction writes rd
- halted  out  1  sticky HALT issued

Behaviour:
- Reset (rst_n=0 at posedge): buffer emptied, halt_seen=0, halted=0, out_valid=0. All decoded outputs read 0 while out_valid=0. Reset mid-operation discards buffered entries with no issue.
- Ready and accept:
  - in_ready = (count<DEPTH) & ~halt_seen, derived from registers only.
  - Accept when in_valid&in_ready. The decode is written into the tail at that posedge.
- Latency: an entry accepted at edge N into an empty buffer gives out_valid=1 after edge N, i.e. 1 cycle.
- Pop: when out_valid&out_ready. Order is strict FIFO.
- Simultaneous push and pop:
  - count=1: count stays 1 and head advances.
  - count=2: no push is possible; the pop frees a slot and in_ready=1 the next cycle.
- Output hold: while out_valid&~out_ready, all decoded outputs must stay stable.
- HALT (op 00000):
  - Accepting HALT sets halt_seen, so in_ready=0 from the next cycle until reset.
  - Entries already buffered still issue.
  - halted goes to 1 the cycle after the HALT entry pops.
- Field decode:
  - rs = instr[10:8] always.
  - rt = instr[7:5].
  - rd:
    - R-format (op 11011, 11010, 111xx): instr[4:2].
    - I-format-1 (010xx, 101xx, 1000x, 10011): instr[7:5].
    - LBI and SLBI: instr[10:8].
    - JAL and JALR: R7_LINK.
- Immediate extension:
  - imm5 sign-extended: ADDI, SUBI, ST, LD, STU.
  - imm5 zero-extended: XORI, ANDNI, shift-immediates 101xx.
  - imm8 sign-extended: BEQZ/BNEZ/BLTZ/BGEZ (011xx), LBI, JR, JALR.
  - imm8 zero-extended: SLBI.
  - disp11 sign-extended: J, JAL.
  - All others: imm=0.
- b_sel_imm = 1 for every immediate form above except the branches, J and JAL. Those feed imm to the PC adder and b_sel_imm=0.
- ALU controls (all others 0):
  - SUBI: inv_a=1, cin=1.
  - R-format 11011 with sub_op 01 (SUB): inv_a=1, cin=1.
  - 11011 with sub_op 11 (ANDN): inv_b=1.
  - ANDNI: inv_b=1.
  - SEQ, SLT, SLE: inv_b=1, cin=1.
  - SCO: no inversion, cin=0.
- reg_wr = 1 for 010xx, 101xx, 10001, 10011, 11xxx, 00110, 00111.
- reg_wr = 0 for HALT, NOP, siic, RTI, ST, branches, J, JR.

Test Plan:
- instr=0xDA65 (SUB R1,R2,R3), out_ready=1 → next cycle: op=11011, sub_op=01, inv_a=1, inv_b=0, cin=1, rs=2, rt=3, rd=1, b_sel_imm=0, reg_wr=1.
- 0x417F (ADDI R3,R1,-1) then 0x5170 (XORI R3,R1,16) on back-to-back cycles → first issues imm=0xFFFF, rd=3, b_sel_imm=1; second issues imm=0x0010; order preserved.
- out_ready=0; push 0x92FF (SLBI R2,0xFF) and 0x37FF (JAL -1) → in_ready=0 after the second accept; head held with imm=0x00FF, rd=2. Raise out_ready → JAL issues with imm=0xFFFF, rd=7, reg_wr=1, b_sel_imm=0.
- Push 0x0000 (HALT) then hold in_valid=1 with 0xDA65 → in_ready=0 from the next cycle; the SUB is never accepted; halted=1 the cycle after HALT pops.
- Two entries buffered, then rst_n=0 for one edge → out_valid=0, in_ready=1, halted=0; nothing issues afterwards.
